// File: rtl/can_tx_scheduler.sv
// Purpose : round-robin scheduler feeding four frame requesters into one CAN packet layer,
//           with non-ack retry (gap-separated) and a per-attempt timeout abort.
// Latency : grant registered at the IDLE edge; tx_start rises the next cycle; done_pulse is registered.
// Backpressure: one job in flight; requesters hold req_valid until req_accept, then wait for done_pulse.
// Ports   : clk/rstn (async active-low); req_valid[4], req_data[128] (32 bits per requester),
//           req_accept/done_pulse/done_ok[4]; tx_start/tx_data[32]/tx_done/tx_acked to the packet
//           layer; busy, fail_cnt[8] (saturating), timeout_flag (sticky).
module can_tx_scheduler #(
    parameter logic [3:0]  MAX_RETRY = 4'd3,
    parameter logic [15:0] GAP_CYC   = 16'd16,
    parameter logic [23:0] TIMEOUT   = 24'd2000000
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [3:0]   req_valid,
    input  logic [127:0] req_data,
    output logic [3:0]   req_accept,
    output logic [3:0]   done_pulse,
    output logic [3:0]   done_ok,
    output logic         tx_start,
    output logic [31:0]  tx_data,
    input  logic         tx_done,
    input  logic         tx_acked,
    output logic         busy,
    output logic [7:0]   fail_cnt,
    output logic         timeout_flag
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t       state, state_nxt;
    logic [1:0]   last_grant, last_grant_nxt;
    logic [1:0]   cur, cur_nxt;
    logic [3:0]   retry_cnt, retry_cnt_nxt;
    logic [23:0]  timer, timer_nxt;
    logic [15:0]  gap_cnt, gap_cnt_nxt;
    logic [31:0]  tx_data_nxt;
    logic [3:0]   req_accept_nxt;
    logic [3:0]   done_pulse_nxt;
    logic [3:0]   done_ok_nxt;
    logic [7:0]   fail_cnt_nxt;
    logic         timeout_flag_nxt;

    // Round-robin search: first set request at or after last_grant+1.
    logic         grant_found;
    logic [1:0]   grant_idx;
    logic [1:0]   cand;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        cand        = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = last_grant + 2'(k + 1);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // tx_start decodes the state register, so an async reset drops it immediately.
    assign tx_start = (state == START);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            last_grant   <= 2'd3;
            cur          <= 2'd0;
            retry_cnt    <= 4'd0;
            timer        <= 24'd0;
            gap_cnt      <= 16'd0;
            tx_data      <= 32'd0;
            req_accept   <= 4'd0;
            done_pulse   <= 4'd0;
            done_ok      <= 4'd0;
            fail_cnt     <= 8'd0;
            timeout_flag <= 1'b0;
        end else begin
            state        <= state_nxt;
            last_grant   <= last_grant_nxt;
            cur          <= cur_nxt;
            retry_cnt    <= retry_cnt_nxt;
            timer        <= timer_nxt;
            gap_cnt      <= gap_cnt_nxt;
            tx_data      <= tx_data_nxt;
            req_accept   <= req_accept_nxt;
            done_pulse   <= done_pulse_nxt;
            done_ok      <= done_ok_nxt;
            fail_cnt     <= fail_cnt_nxt;
            timeout_flag <= timeout_flag_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        last_grant_nxt   = last_grant;
        cur_nxt          = cur;
        retry_cnt_nxt    = retry_cnt;
        timer_nxt        = timer;
        gap_cnt_nxt      = gap_cnt;
        tx_data_nxt      = tx_data;
        req_accept_nxt   = 4'd0;
        done_pulse_nxt   = 4'd0;
        done_ok_nxt      = 4'd0;
        fail_cnt_nxt     = fail_cnt;
        timeout_flag_nxt = timeout_flag;

        case (state)
            IDLE: begin
                // The done_pulse cycle is spent here, so a new grant can never
                // coincide with the previous job's completion.
                if (grant_found) begin
                    tx_data_nxt    = req_data[{grant_idx, 5'b00000} +: 32];
                    req_accept_nxt = 4'b0001 << grant_idx;
                    cur_nxt        = grant_idx;
                    retry_cnt_nxt  = 4'd0;
                    timer_nxt      = 24'd0;
                    state_nxt      = START;
                end
            end

            START: begin
                // tx_done is examined before the timeout so a coincident result wins.
                if (tx_done) begin
                    if (tx_acked) begin
                        state_nxt      = IDLE;
                        done_pulse_nxt = 4'b0001 << cur;
                        done_ok_nxt    = 4'b0001 << cur;
                        last_grant_nxt = cur;
                    end else if (retry_cnt < MAX_RETRY) begin
                        retry_cnt_nxt = retry_cnt + 4'd1;
                        gap_cnt_nxt   = GAP_CYC;
                        state_nxt     = GAP;
                    end else begin
                        state_nxt      = IDLE;
                        done_pulse_nxt = 4'b0001 << cur;
                        last_grant_nxt = cur;
                        if (fail_cnt != 8'hFF) begin
                            fail_cnt_nxt = fail_cnt + 8'd1;
                        end
                    end
                end else if (timer == TIMEOUT - 24'd1) begin
                    // Timeout aborts the whole job; no retry is attempted.
                    state_nxt        = IDLE;
                    done_pulse_nxt   = 4'b0001 << cur;
                    last_grant_nxt   = cur;
                    timeout_flag_nxt = 1'b1;
                    if (fail_cnt != 8'hFF) begin
                        fail_cnt_nxt = fail_cnt + 8'd1;
                    end
                end else begin
                    timer_nxt = timer + 24'd1;
                end
            end

            GAP: begin
                // Loaded with GAP_CYC, so GAP lasts GAP_CYC cycles (values N..1).
                if (gap_cnt != 16'd0) begin
                    gap_cnt_nxt = gap_cnt - 16'd1;
                end
                if (gap_cnt <= 16'd1) begin
                    state_nxt = START;
                    timer_nxt = 24'd0;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Bench for can_tx_scheduler: two instances share stimulus; dut_a uses default
// parameters, dut_b uses TIMEOUT=100 for the timeout corner cases.
module tb_can_tx_scheduler;

    logic         clk;
    logic         rstn;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic         tx_done;
    logic         tx_acked;

    logic [3:0]   acc_a, dp_a, ok_a;
    logic         txs_a, busy_a, tf_a;
    logic [31:0]  txd_a;
    logic [7:0]   fc_a;

    logic [3:0]   acc_b, dp_b, ok_b;
    logic         txs_b, busy_b, tf_b;
    logic [31:0]  txd_b;
    logic [7:0]   fc_b;

    int checks = 0;
    int errors = 0;

    can_tx_scheduler dut_a (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
        .req_accept(acc_a), .done_pulse(dp_a), .done_ok(ok_a),
        .tx_start(txs_a), .tx_data(txd_a), .tx_done(tx_done), .tx_acked(tx_acked),
        .busy(busy_a), .fail_cnt(fc_a), .timeout_flag(tf_a)
    );

    can_tx_scheduler #(.TIMEOUT(24'd100)) dut_b (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
        .req_accept(acc_b), .done_pulse(dp_b), .done_ok(ok_b),
        .tx_start(txs_b), .tx_data(txd_b), .tx_done(tx_done), .tx_acked(tx_acked),
        .busy(busy_b), .fail_cnt(fc_b), .timeout_flag(tf_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        req_valid = 4'd0;
        tx_done   = 1'b0;
        tx_acked  = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] dat;
        int          lat;
        int          nacks;
        logic        fin_ack;
        logic [1:0]  g;
        logic        ok;
        logic [7:0]  fcnt;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int n;
        int cnt;

        tbl[0]  = '{4'b0101, 32'h1111_0000, 100, 0, 1'b1, 2'd0, 1'b1, 8'd0};
        tbl[1]  = '{4'b0101, 32'h2222_0001, 100, 0, 1'b1, 2'd2, 1'b1, 8'd0};
        tbl[2]  = '{4'b0101, 32'h3333_0002, 100, 0, 1'b1, 2'd0, 1'b1, 8'd0};
        tbl[3]  = '{4'b0101, 32'h4444_0003, 100, 0, 1'b1, 2'd2, 1'b1, 8'd0};
        tbl[4]  = '{4'b0010, 32'hDEAD_BEEF,   5, 3, 1'b1, 2'd1, 1'b1, 8'd0};
        tbl[5]  = '{4'b0010, 32'h5555_0005,   5, 3, 1'b0, 2'd1, 1'b0, 8'd1};
        tbl[6]  = '{4'b1111, 32'h6666_0006,   3, 0, 1'b1, 2'd2, 1'b1, 8'd1};
        tbl[7]  = '{4'b1001, 32'h7777_0007,   3, 0, 1'b1, 2'd3, 1'b1, 8'd1};
        tbl[8]  = '{4'b1001, 32'h8888_0008,   3, 1, 1'b1, 2'd0, 1'b1, 8'd1};
        tbl[9]  = '{4'b1000, 32'h9999_0009,   3, 0, 1'b1, 2'd3, 1'b1, 8'd1};
        tbl[10] = '{4'b0100, 32'hAAAA_000A,   2, 0, 1'b1, 2'd2, 1'b1, 8'd1};

        rstn      = 1'b0;
        req_valid = 4'd0;
        req_data  = '0;
        tx_done   = 1'b0;
        tx_acked  = 1'b0;
        @(negedge clk);
        chk("reset tx_start",     32'(txs_a), 32'd0);
        chk("reset tx_data",      txd_a,      32'd0);
        chk("reset req_accept",   32'(acc_a), 32'd0);
        chk("reset done_pulse",   32'(dp_a),  32'd0);
        chk("reset done_ok",      32'(ok_a),  32'd0);
        chk("reset busy",         32'(busy_a), 32'd0);
        chk("reset fail_cnt",     32'(fc_a),  32'd0);
        chk("reset timeout_flag", 32'(tf_a),  32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Table-driven jobs on dut_a.
        for (int e = 0; e < 11; e++) begin
            for (int i = 0; i < 4; i++) begin
                req_data[32*i +: 32] = (i == int'(tbl[e].g)) ? tbl[e].dat : ~tbl[e].dat;
            end
            req_valid = tbl[e].valid;
            n = 0;
            while (acc_a == 4'd0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("v%0d accept", e), 32'(acc_a), 32'(4'b0001 << tbl[e].g));
            chk($sformatf("v%0d tx_data", e), txd_a, tbl[e].dat);
            chk($sformatf("v%0d tx_start", e), 32'(txs_a), 32'd1);
            req_data = {4{32'h0BAD_F00D}};
            for (int a = 0; a <= tbl[e].nacks; a++) begin
                repeat (tbl[e].lat - 1) @(negedge clk);
                tx_done  = 1'b1;
                tx_acked = (a == tbl[e].nacks) ? tbl[e].fin_ack : 1'b0;
                @(negedge clk);
                tx_done  = 1'b0;
                tx_acked = 1'b0;
                if (a < tbl[e].nacks) begin
                    chk($sformatf("v%0d no done on retry", e), 32'(dp_a), 32'd0);
                    cnt = 0;
                    while (!txs_a && cnt < 100) begin
                        cnt++;
                        @(negedge clk);
                    end
                    chk($sformatf("v%0d gap len", e), cnt, 32'd16);
                    chk($sformatf("v%0d tx_data held", e), txd_a, tbl[e].dat);
                end
            end
            chk($sformatf("v%0d done_pulse", e), 32'(dp_a), 32'(4'b0001 << tbl[e].g));
            chk($sformatf("v%0d done_ok", e), 32'(ok_a), tbl[e].ok ? 32'(4'b0001 << tbl[e].g) : 32'd0);
            chk($sformatf("v%0d busy", e), 32'(busy_a), 32'd0);
            chk($sformatf("v%0d fail_cnt", e), 32'(fc_a), 32'(tbl[e].fcnt));
            chk($sformatf("v%0d no accept with done", e), 32'(acc_a), 32'd0);
            req_valid = 4'd0;
            @(negedge clk);
            chk($sformatf("v%0d done cleared", e), 32'(dp_a), 32'd0);
        end

        // Reset mid-job: last_grant is 2 here, so without reset 1111 would go to 3.
        req_valid = 4'b0100;
        n = 0;
        while (acc_a == 4'd0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst job accept", 32'(acc_a), 32'd4);
        repeat (3) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("rst tx_start async", 32'(txs_a), 32'd0);
        chk("rst busy async", 32'(busy_a), 32'd0);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (dp_a != 4'd0) cnt++;
        end
        rstn = 1'b1;
        req_valid = 4'b1111;
        repeat (3) begin
            @(negedge clk);
            if (dp_a != 4'd0) cnt++;
            if (acc_a != 4'd0) break;
        end
        chk("rst no done_pulse", cnt, 32'd0);
        chk("rst next grant", 32'(acc_a), 32'd1);

        // Timeout abort on dut_b.
        do_reset();
        req_valid = 4'b0001;
        n = 0;
        while (acc_b == 4'd0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_valid = 4'd0;
        cnt = 0;
        while (txs_b && cnt < 300) begin
            cnt++;
            @(negedge clk);
        end
        chk("to tx_start high cycles", cnt, 32'd100);
        chk("to done_pulse", 32'(dp_b), 32'd1);
        chk("to done_ok", 32'(ok_b), 32'd0);
        chk("to timeout_flag", 32'(tf_b), 32'd1);
        chk("to fail_cnt", 32'(fc_b), 32'd1);

        // tx_done while IDLE must be ignored.
        @(negedge clk);
        tx_done  = 1'b1;
        tx_acked = 1'b0;
        @(negedge clk);
        tx_done = 1'b0;
        chk("idle tx_done no pulse", 32'(dp_b), 32'd0);
        @(negedge clk);
        chk("idle tx_done fail_cnt", 32'(fc_b), 32'd1);
        chk("idle busy", 32'(busy_b), 32'd0);

        // tx_done coinciding with the timeout cycle wins.
        do_reset();
        req_valid = 4'b0001;
        n = 0;
        while (acc_b == 4'd0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_valid = 4'd0;
        repeat (99) @(negedge clk);
        chk("coin still started", 32'(txs_b), 32'd1);
        tx_done  = 1'b1;
        tx_acked = 1'b1;
        @(negedge clk);
        tx_done  = 1'b0;
        tx_acked = 1'b0;
        chk("coin done_pulse", 32'(dp_b), 32'd1);
        chk("coin done_ok", 32'(ok_b), 32'd1);
        chk("coin timeout_flag", 32'(tf_b), 32'd0);
        chk("coin fail_cnt", 32'(fc_b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
